seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised serial bit-sequence detector; successor to the fixed 2-bit-state pattern detector.
- Pattern and pattern length are runtime-programmable up to MAX_LEN bits.
- Supports overlapping and non-overlapping detection modes, an input-valid qualifier and a saturating match counter.
- Sits on a serial data path after bit-sync logic; its detect pulse feeds frame-alignment / control logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, 4, width of cfg_len; must hold MAX_LEN.
- CNT_W, 8, width of match_count.
- RST_PATTERN, 8'b0000_1011, pattern after reset (LSB-aligned).
- RST_LEN, 4, pattern length after reset.
- RST_OVERLAP, 1, overlap mode after reset.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- cfg_load  input  1  load cfg_pattern/cfg_len/cfg_overlap; clears history and count
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the oldest bit, bit [0] the newest
- cfg_len  input  LEN_W  pattern length
- cfg_overlap  input  1  1 = overlapping matches allowed
- din_valid  input  1  din is sampled only when high
- din  input  1  serial data bit
- clr_count  input  1  synchronous clear of match_count
- detected  output  1  one-cycle pulse per match
- match_count  output  CNT_W  saturating number of matches
- cfg_err  output  1  active configuration invalid (len 0)

Behaviour:
- Reset: pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP; history=0, fill=0; detected=0, match_count=0, cfg_err=0.
- Internal state:
  - history: MAX_LEN-bit shift register; new bit enters at [0].
  - fill: count of valid history bits, saturating at MAX_LEN.
- Accepted bit = din_valid high and cfg_load low at the clock edge. On accept:
  - history <= {history[MAX_LEN-2:0], din}
  - fill <= min(fill+1, MAX_LEN)
- Match condition, evaluated on the post-shift history:
  - fill_next >= len, and
  - history_next[len-1:0] == pattern[len-1:0]; bits above len are ignored.
- Latency: detected is registered and high in the cycle after the edge that accepted the completing bit. It is high for exactly one cycle per match and never high without an accepted bit.
- Overlap=1: history and fill are kept after a match (1011011 gives 2 matches for pattern 1011).
- Overlap=0: fill <= 0 on a match, so the next match needs len fresh bits.
- match_count increments on each match and saturates at 2^CNT_W-1.
- clr_count: match_count <= 0. If a match occurs in the same cycle, the result is 1 (the match wins over the clear for that bit).
- cfg_load (highest priority):
  - Registers pattern, overlap, and len clamped to MAX_LEN if cfg_len > MAX_LEN.
  - Clears history, fill and match_count; detected <= 0.
  - A din_valid bit in the same cycle is dropped.
- cfg_len == 0 after load: cfg_err=1, no detection occurs, history still shifts. cfg_err clears on the next valid load. cfg_err is registered with the config.
- din_valid low: all state holds; detected <= 0.
- Reset mid-stream: immediate asynchronous return to reset values; a partially matched sequence is discarded.
- len == 1: every accepted bit equal to pattern[0] matches, regardless of mode.

Test Plan:
- After reset, pattern 1011 overlap; stream 1,0,1,1,0,1,1 with din_valid=1 -> detected pulses in the cycles after bits 4 and 7; match_count=2.
- cfg_load pattern 1011, len 4, overlap=0; same 7-bit stream -> single pulse after bit 4; match_count=1.
- Pattern 1011 with din_valid toggling 1,0 each cycle while presenting 1,x,0,x,1,x,1 -> one pulse, one cycle after the 4th valid bit; idle bits ignored.
- cfg_load len=12, MAX_LEN=8, pattern 8'hA5 -> len clamped to 8; stream 1010_0101 -> one pulse. Then cfg_load len=0 -> cfg_err=1 and no pulses on any stream.
- CNT_W=2, overlap, len=1, pattern 1; stream of five 1s -> match_count 1,2,3,3,3. clr_count asserted with a matching bit -> match_count=1.
- Assert reset after bits 1,0,1 of 1011, release, send 1 -> no detection; send 0,1,1 -> detected after the 4th post-reset bit... specifically after the final 1 of 1,0,1,1 counted from the first post-reset bit (pulse after post-reset bit 4).

Source files
------------

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-sequence detector with overlap control,
// input qualifier and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned         MAX_LEN     = 8,
  parameter int unsigned         LEN_W       = 4,
  parameter int unsigned         CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]  RST_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter logic [LEN_W-1:0]    RST_LEN     = LEN_W'(4),
  parameter bit                  RST_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               clr_count,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               overlap_q, overlap_d;
  logic               err_q, err_d;
  logic               det_q, det_d;

  logic               accept;
  logic               hit;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;

  // Only the youngest len_q history bits take part in the compare.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign len_mask[i] = (LEN_W'(i) < len_q);
  end

  assign accept     = din_valid & ~cfg_load;
  assign hist_shift = {hist_q[MAX_LEN-2:0], din};
  assign fill_inc   = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
  assign hit        = accept && !err_q && (fill_inc >= len_q) &&
                      (((hist_shift ^ pattern_q) & len_mask) == '0);

  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    len_d     = len_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    overlap_d = overlap_q;
    err_d     = err_q;
    det_d     = 1'b0;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      overlap_d = cfg_overlap;
      err_d     = (cfg_len == '0);
      hist_d    = '0;
      fill_d    = '0;
      cnt_d     = '0;
    end else begin
      if (accept) begin
        hist_d = hist_shift;
        // Non-overlap mode restarts the fill so the next match needs len fresh bits.
        fill_d = (hit && !overlap_q) ? '0 : fill_inc;
        det_d  = hit;
      end
      if (hit) begin
        if (clr_count)        cnt_d = CNT_W'(1);
        else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else if (clr_count) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= RST_PATTERN;
      hist_q    <= '0;
      len_q     <= RST_LEN;
      fill_q    <= '0;
      cnt_q     <= '0;
      overlap_q <= RST_OVERLAP;
      err_q     <= 1'b0;
      det_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      overlap_q <= overlap_d;
      err_q     <= err_d;
      det_q     <= det_d;
    end
  end

  assign detected    = det_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule
